ram_arbiter: RTL and testbench

- Two-master controller in front of the single-port byte-addressed data RAM.
- Shares the RAM between the instruction-fetch port and the load/store port.
- Sequences each access as a short state machine and turns byte/halfword stores into read-modify-write, because the RAM only writes full 32-bit words.
- Sits between the core's fetch/LSU and the RAM's data_address/mem_read/mem_write/data_in/data_out port.

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master front end for a single-port word RAM: arbitrates fetch vs load/store,
// sequences each access IDLE->READ/WRITE->RESP and turns sub-word stores into read-modify-write.
module ram_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_ready,
    output logic [31:0]           d_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state_q;
    logic                  last_data_q;   // 1 = data port won the last grant
    logic                  port_data_q;
    logic                  we_q;
    logic                  half_q;
    logic [15:0]           wdata_q;
    logic                  if_ready_q, d_ready_q, ram_read_q, ram_write_q;
    logic [31:0]           if_rdata_q, d_rdata_q, ram_wdata_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;

    logic                  gnt_data_d;
    logic                  sel_we_d;
    logic [1:0]            sel_size_d;
    logic [ADDR_WIDTH-1:0] sel_addr_d;
    logic [31:0]           sel_wdata_d;
    logic [31:0]           merge_d;

    always_comb begin
        if (if_req && d_req) gnt_data_d = ROUND_ROBIN ? !last_data_q : 1'b1;
        else                 gnt_data_d = d_req;
        // A fetch is a word load, so its operands collapse to we=0, size=word.
        sel_we_d    = gnt_data_d & d_we;
        sel_size_d  = gnt_data_d ? d_size  : 2'b10;
        sel_addr_d  = gnt_data_d ? d_addr  : if_addr;
        sel_wdata_d = gnt_data_d ? d_wdata : 32'h0;
        merge_d     = half_q ? {ram_rdata[31:16], wdata_q}
                             : {ram_rdata[31:8],  wdata_q[7:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            port_data_q <= 1'b0;
            we_q        <= 1'b0;
            half_q      <= 1'b0;
            wdata_q     <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            ram_wdata_q <= '0;
            ram_addr_q  <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        port_data_q <= gnt_data_d;
                        last_data_q <= gnt_data_d;
                        we_q        <= sel_we_d;
                        half_q      <= (sel_size_d == 2'b01);
                        wdata_q     <= sel_wdata_d[15:0];
                        ram_addr_q  <= sel_addr_d;
                        if (sel_we_d && sel_size_d[1]) begin
                            ram_write_q <= 1'b1;
                            ram_wdata_q <= sel_wdata_d;
                            state_q     <= WRITE;
                        end else begin
                            ram_read_q <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    ram_read_q <= 1'b0;
                    // Only sub-word stores reach READ with we set.
                    if (we_q) begin
                        ram_write_q <= 1'b1;
                        ram_wdata_q <= merge_d;
                        state_q     <= WRITE;
                    end else begin
                        ram_addr_q <= '0;
                        if (port_data_q) begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= ram_rdata;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= ram_rdata;
                        end
                        state_q <= RESP;
                    end
                end
                WRITE: begin
                    ram_write_q <= 1'b0;
                    ram_addr_q  <= '0;
                    ram_wdata_q <= '0;
                    d_ready_q   <= 1'b1;
                    d_rdata_q   <= '0;
                    state_q     <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboarded bench for ram_arbiter: random two-master traffic against a word-level
// memory model, plus directed latency, RMW, reset and priority scenarios.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req, if_ready, d_req, d_we, d_ready, ram_read, ram_write;
    logic [1:0]  d_size;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

    logic        if_req0, if_ready0, d_req0, d_we0, d_ready0, ram_read0, ram_write0;
    logic [1:0]  d_size0;
    logic [31:0] if_addr0, if_rdata0, d_addr0, d_wdata0, d_rdata0, ram_addr0, ram_wdata0, ram_rdata0;

    ram_arbiter #(.ADDR_WIDTH(32), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.ADDR_WIDTH(32), .ROUND_ROBIN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_ready(if_ready0), .if_rdata(if_rdata0),
        .d_req(d_req0), .d_we(d_we0), .d_size(d_size0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_ready(d_ready0), .d_rdata(d_rdata0),
        .ram_addr(ram_addr0), .ram_read(ram_read0), .ram_write(ram_write0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic logic [31:0] preset_val(input int i);
        logic [31:0] v;
        v = (32'(i) * 32'h9E37_79B1) ^ 32'h3C3C_0F0F;
        case (i)
            16:      v = 32'hDEAD_BEEF;
            64, 68:  v = 32'hAABB_CCDD;
            128:     v = 32'h5A5A_0001;
            default: ;
        endcase
        return v;
    endfunction

    // RAM model: word per byte address, combinational read, write at the clock edge
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = preset_val(i);
        forever begin
            @(posedge clk);
            if (ram_write) mem[ram_addr[9:0]] = ram_wdata;
        end
    end
    assign ram_rdata  = ram_read  ? mem[ram_addr[9:0]] : 32'h0;
    assign ram_rdata0 = ram_read0 ? (ram_addr0 ^ 32'h5555_5555) : 32'h0;

    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    logic        seq[$];   // 0 = fetch completion, 1 = data completion

    // Monitor: pops the scoreboard on every ready and checks bus invariants
    initial begin
        logic prev_if, prev_d;
        prev_if = 1'b0;
        prev_d  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ram_read && ram_write) fail_msg("rw_exclusive");
                if ((ram_read || ram_write) && ram_addr[31:10] != 22'h0) fail_msg("addr_range");
                if (!ram_read && !ram_write && !if_ready && !d_ready) begin
                    check("idle_addr", ram_addr, 32'h0);
                    check("idle_wdata", ram_wdata, 32'h0);
                end
                if (if_ready && d_ready) fail_msg("dual_ready");
                if (if_ready) begin
                    if (prev_if) fail_msg("if_ready_pulse");
                    if (exp_if.size() == 0) fail_msg("if_unexpected_ready");
                    else check("if_rdata", if_rdata, exp_if.pop_front());
                    seq.push_back(1'b0);
                end
                if (d_ready) begin
                    if (prev_d) fail_msg("d_ready_pulse");
                    if (exp_d.size() == 0) fail_msg("d_unexpected_ready");
                    else check("d_rdata", d_rdata, exp_d.pop_front());
                    seq.push_back(1'b1);
                end
            end
            prev_if = if_ready;
            prev_d  = d_ready;
        end
    end

    task automatic wait_ready(input bit is_d, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(is_d ? d_ready : if_ready) && cyc < 40);
        if (!(is_d ? d_ready : if_ready)) fail_msg(is_d ? "d_timeout" : "if_timeout");
    endtask

    task automatic fetch_master(input int n);
        int cyc;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = 32'h200 + 32'($urandom_range(0, 63) * 4);
            if_addr = a;
            if_req  = 1'b1;
            exp_if.push_back(ref_mem[a[9:0]]);
            wait_ready(1'b0, cyc);
        end
        if_req = 1'b0;
    endtask

    task automatic data_master(input int n);
        int cyc;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a, w;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'h100 + 32'($urandom_range(0, 255));
            w  = $urandom;
            d_we = we; d_size = sz; d_addr = a; d_wdata = w; d_req = 1'b1;
            if (we) begin
                exp_d.push_back(32'h0);
                case (sz)
                    2'b00:   ref_mem[a[9:0]][7:0]  = w[7:0];
                    2'b01:   ref_mem[a[9:0]][15:0] = w[15:0];
                    default: ref_mem[a[9:0]]       = w;
                endcase
            end else begin
                exp_d.push_back(ref_mem[a[9:0]]);
            end
            wait_ready(1'b1, cyc);
        end
        d_req = 1'b0;
    endtask

    task automatic dir_d(input logic we, input logic [1:0] sz, input logic [31:0] a, w, ex,
                         output int cyc, output int rc, output int wc, output logic [31:0] wd);
        @(negedge clk);
        d_we = we; d_size = sz; d_addr = a; d_wdata = w; d_req = 1'b1;
        exp_d.push_back(ex);
        cyc = 0; rc = 0; wc = 0; wd = 32'h0;
        do begin
            @(negedge clk);
            cyc++;
            if (ram_read) rc++;
            if (ram_write) begin wc++; wd = ram_wdata; end
        end while (!d_ready && cyc < 40);
        if (!d_ready) fail_msg("dir_d_timeout");
        d_req = 1'b0;
    endtask

    task automatic dir_f(input logic [31:0] a, ex, output int cyc, output int rc, output int wc);
        @(negedge clk);
        if_addr = a; if_req = 1'b1;
        exp_if.push_back(ex);
        cyc = 0; rc = 0; wc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (ram_read) rc++;
            if (ram_write) wc++;
        end while (!if_ready && cyc < 40);
        if (!if_ready) fail_msg("dir_f_timeout");
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        fail_msg("global_watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, rc, wc, dcnt, t;
        logic [31:0] wd, wacc;
        logic fdone, first_seen, first_data;

        for (int i = 0; i < 1024; i++) ref_mem[i] = preset_val(i);
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        if_req0 = 0; if_addr0 = 0; d_req0 = 0; d_we0 = 0; d_size0 = 0; d_addr0 = 0; d_wdata0 = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'h0, ram_read, ram_write, if_ready, d_ready}, 32'h0);
        check("rst_addr", ram_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        rst = 1'b0;

        // Continuous contention from reset: completions must alternate starting with fetch
        fork
            fetch_master(40);
            data_master(40);
        join
        check("rr_count", 32'(seq.size()), 32'd80);
        for (int i = 0; i < seq.size(); i++) check("rr_order", 32'(seq[i]), 32'(i % 2));
        for (int a = 32'h100; a < 32'h200; a++) check("mem_final", mem[a], ref_mem[a]);

        dir_f(32'h10, 32'hDEAD_BEEF, cyc, rc, wc);
        check("fetch_latency", 32'(cyc), 32'd2);
        check("fetch_reads", 32'(rc), 32'd1);
        check("fetch_writes", 32'(wc), 32'd0);

        dir_d(1'b1, 2'b10, 32'h20, 32'h1122_3344, 32'h0, cyc, rc, wc, wd);
        check("wst_latency", 32'(cyc), 32'd2);
        check("wst_reads", 32'(rc), 32'd0);
        check("wst_writes", 32'(wc), 32'd1);
        check("wst_wdata", wd, 32'h1122_3344);
        dir_d(1'b0, 2'b10, 32'h20, 32'h0, 32'h1122_3344, cyc, rc, wc, wd);
        check("ld_latency", 32'(cyc), 32'd2);

        dir_d(1'b1, 2'b00, 32'h40, 32'hFFFF_FF5A, 32'h0, cyc, rc, wc, wd);
        check("bst_latency", 32'(cyc), 32'd3);
        check("bst_reads", 32'(rc), 32'd1);
        check("bst_writes", 32'(wc), 32'd1);
        check("bst_wdata", wd, 32'hAABB_CC5A);
        dir_d(1'b1, 2'b01, 32'h44, 32'hCAFE_1234, 32'h0, cyc, rc, wc, wd);
        check("hst_latency", 32'(cyc), 32'd3);
        check("hst_wdata", wd, 32'hAABB_1234);
        dir_d(1'b0, 2'b11, 32'h40, 32'h0, 32'hAABB_CC5A, cyc, rc, wc, wd);

        // Held data request after ready plus a pending fetch: expect D, F, D
        seq.delete();
        @(negedge clk);
        d_we = 0; d_size = 2'b10; d_addr = 32'h20; d_req = 1'b1;
        exp_d.push_back(32'h1122_3344);
        exp_d.push_back(32'h1122_3344);
        @(negedge clk);
        if_addr = 32'h10; if_req = 1'b1;
        exp_if.push_back(32'hDEAD_BEEF);
        dcnt = 0; fdone = 1'b0; t = 0;
        while (!(dcnt == 2 && fdone) && t < 40) begin
            @(negedge clk);
            t++;
            if (d_ready) begin dcnt++; if (dcnt == 2) d_req = 1'b0; end
            if (if_ready) begin fdone = 1'b1; if_req = 1'b0; end
        end
        d_req = 1'b0; if_req = 1'b0;
        if (t >= 40) fail_msg("held_timeout");
        check("held_count", 32'(seq.size()), 32'd3);
        if (seq.size() == 3) check("held_order", {29'h0, seq[0], seq[1], seq[2]}, 32'b101);

        // Reset asserted while a word store sits in WRITE
        @(negedge clk);
        d_we = 1; d_size = 2'b10; d_addr = 32'h80; d_wdata = 32'h9999_9999; d_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ram_write && t < 10);
        if (!ram_write) fail_msg("rst_write_not_seen");
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        check("midrst_ctrl", {28'h0, ram_read, ram_write, if_ready, d_ready}, 32'h0);
        check("midrst_addr", ram_addr, 32'h0);
        check("midrst_wdata", ram_wdata, 32'h0);
        check("midrst_if_rdata", if_rdata, 32'h0);
        check("midrst_d_rdata", d_rdata, 32'h0);
        repeat (2) @(negedge clk);
        check("midrst_mem", mem[10'h80], 32'h5A5A_0001);
        rst = 1'b0;
        dir_d(1'b0, 2'b10, 32'h80, 32'h0, 32'h5A5A_0001, cyc, rc, wc, wd);
        check("postrst_latency", 32'(cyc), 32'd2);

        // Fixed priority instance: data wins a simultaneous request
        @(negedge clk);
        if_addr0 = 32'h30; if_req0 = 1'b1;
        d_addr0 = 32'h34; d_we0 = 1'b0; d_size0 = 2'b10; d_req0 = 1'b1;
        first_seen = 1'b0; first_data = 1'b0; fdone = 1'b0; dcnt = 0; t = 0; wacc = 32'h0;
        while (!(fdone && dcnt == 1) && t < 40) begin
            @(negedge clk);
            t++;
            if (ram_write0) wacc = wacc | ram_wdata0 | 32'h1;
            if (d_ready0) begin
                if (!first_seen) begin first_seen = 1'b1; first_data = 1'b1; end
                check("rr0_d_rdata", d_rdata0, 32'h34 ^ 32'h5555_5555);
                dcnt++; d_req0 = 1'b0;
            end
            if (if_ready0) begin
                if (!first_seen) begin first_seen = 1'b1; first_data = 1'b0; end
                check("rr0_if_rdata", if_rdata0, 32'h30 ^ 32'h5555_5555);
                fdone = 1'b1; if_req0 = 1'b0;
            end
        end
        if (t >= 40) fail_msg("rr0_timeout");
        check("rr0_first_is_data", 32'(first_data), 32'd1);
        check("rr0_no_write", wacc, 32'h0);

        repeat (2) @(negedge clk);
        check("exp_if_empty", 32'(exp_if.size()), 32'd0);
        check("exp_d_empty", 32'(exp_d.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
